mul_seq_ctrl: RTL and testbench

Multi-cycle multiply sequencer for the execute stage. It takes over every instruction decoded as `ALU_OP_MUL` and computes the low 32 bits of the product with an iterative shift-add datapath. It terminates early once the remaining multiplier bits are zero, and stalls the pipeline until the result has been handed back. Exception or branch flushes kill an in-flight multiply.

---
 rtl/mul_seq_ctrl.sv | 147 ++++++++++++++
 tb/tb_mul_seq_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq_ctrl.sv
// Iterative shift-add multiplier for the execute stage: low XLEN bits of op_a*op_b,
// early exit once the remaining multiplier bits are zero, pipeline stall until acked.
module mul_seq_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  input  logic [4:0]        addr_d_in,
  input  logic              kill,
  input  logic              result_ack,
  output logic              stall,
  output logic              result_valid,
  output logic [XLEN-1:0]   result,
  output logic [4:0]        addr_d_out,
  output logic              wrd_reg_out
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [XLEN-1:0]  a_r;
  logic [XLEN-1:0]  b_r;
  logic [XLEN-1:0]  acc_r;
  logic [CNT_W-1:0] cnt_r;
  logic [4:0]       tag_r;
  logic [XLEN-1:0]  result_r;
  logic             result_valid_r;
  logic [4:0]       addr_d_out_r;
  logic             wrd_reg_r;

  logic [XLEN-1:0]  acc_sum_s;
  logic [XLEN-1:0]  b_shift_s;
  logic             last_iter_s;
  logic             accept_s;

  // Carry-out of the partial-product add is dropped: only the low word is kept.
  assign acc_sum_s   = b_r[0] ? (acc_r + a_r) : acc_r;
  assign b_shift_s   = b_r >> 1;
  assign last_iter_s = (b_shift_s == {XLEN{1'b0}}) || (cnt_r == CNT_W'(XLEN - 1));
  assign accept_s    = (state_r == ST_IDLE) && start && !kill;

  // Next-state selection; kill always returns to IDLE.
  always_comb begin
    state_nxt_s = state_r;
    if (kill) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_nxt_s = ST_BUSY;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (last_iter_s) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_BUSY;
          end
        end
        ST_DONE: begin
          if (result_ack) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      a_r            <= {XLEN{1'b0}};
      b_r            <= {XLEN{1'b0}};
      acc_r          <= {XLEN{1'b0}};
      cnt_r          <= {CNT_W{1'b0}};
      tag_r          <= 5'd0;
      result_r       <= {XLEN{1'b0}};
      result_valid_r <= 1'b0;
      addr_d_out_r   <= 5'd0;
      wrd_reg_r      <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (kill) begin
        result_valid_r <= 1'b0;
        wrd_reg_r      <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (start) begin
              a_r   <= op_a;
              b_r   <= op_b;
              acc_r <= {XLEN{1'b0}};
              cnt_r <= {CNT_W{1'b0}};
              tag_r <= addr_d_in;
            end
          end
          ST_BUSY: begin
            acc_r <= acc_sum_s;
            a_r   <= a_r << 1;
            b_r   <= b_shift_s;
            cnt_r <= cnt_r + CNT_W'(1);
            if (last_iter_s) begin
              result_r       <= acc_sum_s;
              result_valid_r <= 1'b1;
              addr_d_out_r   <= tag_r;
              wrd_reg_r      <= (tag_r != 5'd0);
            end
          end
          ST_DONE: begin
            if (result_ack) begin
              result_valid_r <= 1'b0;
              wrd_reg_r      <= 1'b0;
            end
          end
          default: begin
            result_valid_r <= 1'b0;
            wrd_reg_r      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign stall = accept_s
               || ((state_r == ST_BUSY) && !kill)
               || ((state_r == ST_DONE) && !result_ack && !kill);

  assign result_valid = result_valid_r;
  assign result       = result_r;
  assign addr_d_out   = addr_d_out_r;
  assign wrd_reg_out  = wrd_reg_r;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed testbench for mul_seq_ctrl: latency, results, ack handling, kill and reset.
module tb_mul_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  addr_d_in;
  logic        kill;
  logic        result_ack;
  logic        stall;
  logic        result_valid;
  logic [31:0] result;
  logic [4:0]  addr_d_out;
  logic        wrd_reg_out;

  int errors = 0;
  int checks = 0;

  mul_seq_ctrl #(.XLEN(32), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .addr_d_in(addr_d_in), .kill(kill), .result_ack(result_ack),
    .stall(stall), .result_valid(result_valid), .result(result),
    .addr_d_out(addr_d_out), .wrd_reg_out(wrd_reg_out)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs are then set for that cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; kill = 1'b0; result_ack = 1'b0;
    op_a = 32'd0; op_b = 32'd0; addr_d_in = 5'd0;
    tick(); tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({result_valid, result, addr_d_out, wrd_reg_out, stall} !== {1'b0, 32'd0, 5'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got v=%b r=%h a=%0d w=%b s=%b, expected all zero",
               result_valid, result, addr_d_out, wrd_reg_out, stall);
    end
  endtask

  task automatic test_small();
    tick();
    start = 1'b1; op_a = 32'd6; op_b = 32'd7; addr_d_in = 5'd5;
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL small_stall_T: got %b expected 1", stall); end
    for (int c = 1; c <= 3; c++) begin
      tick();
      start = 1'b0; op_a = 32'hDEAD_BEEF; op_b = 32'hFFFF_FFFF; addr_d_in = 5'd9;
      #1;
      checks++;
      if ({stall, result_valid} !== 2'b10) begin
        errors++;
        $display("FAIL small_busy_T+%0d: got stall=%b valid=%b expected stall=1 valid=0", c, stall, result_valid);
      end
    end
    tick();
    result_ack = 1'b1;
    #1;
    checks++;
    if ({result_valid, result, addr_d_out, wrd_reg_out, stall} !== {1'b1, 32'd42, 5'd5, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL small_done_T+4: got v=%b r=%0d a=%0d w=%b s=%b expected v=1 r=42 a=5 w=1 s=0",
               result_valid, result, addr_d_out, wrd_reg_out, stall);
    end
    tick();
    result_ack = 1'b0;
    #1;
    checks++;
    if ({result_valid, wrd_reg_out, stall} !== 3'b000) begin
      errors++;
      $display("FAIL small_idle_T+5: got v=%b w=%b s=%b expected 0 0 0", result_valid, wrd_reg_out, stall);
    end
  endtask

  task automatic test_zero();
    tick();
    start = 1'b1; op_a = 32'h1234_5678; op_b = 32'd0; addr_d_in = 5'd3;
    tick();
    start = 1'b0;
    #1;
    checks++;
    if ({stall, result_valid} !== 2'b10) begin
      errors++;
      $display("FAIL zero_T+1: got stall=%b valid=%b expected 1 0", stall, result_valid);
    end
    tick();
    result_ack = 1'b1;
    #1;
    checks++;
    if ({result_valid, result} !== {1'b1, 32'd0}) begin
      errors++;
      $display("FAIL zero_T+2: got valid=%b result=%h expected 1 00000000", result_valid, result);
    end
    tick();
    result_ack = 1'b0;
  endtask

  task automatic test_worst();
    int n;
    tick();
    start = 1'b1; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF; addr_d_in = 5'd31;
    tick();
    start = 1'b0;
    n = 1;
    while (result_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n != 33) begin
      errors++;
      $display("FAIL worst_latency: valid at T+%0d expected T+33", n);
    end
    checks++;
    if (result !== 32'h0000_0001) begin
      errors++;
      $display("FAIL worst_result: got %h expected 00000001", result);
    end
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
  endtask

  task automatic test_overflow();
    int n;
    tick();
    start = 1'b1; op_a = 32'h8000_0000; op_b = 32'd2; addr_d_in = 5'd0;
    tick();
    start = 1'b0;
    n = 1;
    while (result_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if ({n == 3, result_valid, result, wrd_reg_out, addr_d_out} !== {1'b1, 1'b1, 32'd0, 1'b0, 5'd0}) begin
      errors++;
      $display("FAIL overflow_x0: got T+%0d v=%b r=%h w=%b a=%0d expected T+3 v=1 r=0 w=0 a=0",
               n, result_valid, result, wrd_reg_out, addr_d_out);
    end
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
  endtask

  task automatic test_delayed_ack();
    tick();
    start = 1'b1; op_a = 32'd3; op_b = 32'd5; addr_d_in = 5'd7;
    for (int c = 1; c <= 3; c++) begin
      tick();
      start = 1'b0;
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      #1;
      checks++;
      if ({result_valid, result, stall, wrd_reg_out} !== {1'b1, 32'd15, 1'b1, 1'b1}) begin
        errors++;
        $display("FAIL delayed_hold_%0d: got v=%b r=%0d s=%b w=%b expected v=1 r=15 s=1 w=1",
                 c, result_valid, result, stall, wrd_reg_out);
      end
    end
    tick();
    result_ack = 1'b1;
    #1;
    checks++;
    if ({result_valid, result, stall} !== {1'b1, 32'd15, 1'b0}) begin
      errors++;
      $display("FAIL delayed_ack: got v=%b r=%0d s=%b expected v=1 r=15 s=0", result_valid, result, stall);
    end
    tick();
    result_ack = 1'b0;
    #1;
    checks++;
    if ({result_valid, stall} !== 2'b00) begin
      errors++;
      $display("FAIL delayed_release: got v=%b s=%b expected 0 0", result_valid, stall);
    end
  endtask

  task automatic test_kill();
    int seen_valid;
    seen_valid = 0;
    tick();
    start = 1'b1; op_a = 32'd11; op_b = 32'hFFFF_FFFF; addr_d_in = 5'd4;
    for (int c = 1; c <= 5; c++) begin
      tick();
      start = 1'b0;
      if (result_valid === 1'b1) seen_valid = 1;
    end
    kill = 1'b1;
    #1;
    checks++;
    if ({stall, seen_valid == 1} !== 2'b00) begin
      errors++;
      $display("FAIL kill_cycle: got stall=%b early_valid=%0d expected 0 0", stall, seen_valid);
    end
    tick();
    kill = 1'b0;
    start = 1'b1; op_a = 32'd2; op_b = 32'd3; addr_d_in = 5'd6;
    #1;
    checks++;
    if ({result_valid, stall} !== 2'b01) begin
      errors++;
      $display("FAIL kill_restart_T+6: got v=%b s=%b expected v=0 s=1 (idle, accepting)", result_valid, stall);
    end
    tick();
    start = 1'b0;
    tick();
    #1;
    checks++;
    if (result_valid !== 1'b0) begin errors++; $display("FAIL kill_T+8: got valid=%b expected 0", result_valid); end
    tick();
    result_ack = 1'b1;
    #1;
    checks++;
    if ({result_valid, result, addr_d_out} !== {1'b1, 32'd6, 5'd6}) begin
      errors++;
      $display("FAIL kill_T+9: got v=%b r=%0d a=%0d expected v=1 r=6 a=6", result_valid, result, addr_d_out);
    end
    tick();
    result_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    tick();
    start = 1'b1; op_a = 32'd13; op_b = 32'hFFFF_FFFF; addr_d_in = 5'd9;
    for (int c = 1; c <= 5; c++) begin
      tick();
      start = 1'b0;
    end
    rst = 1'b1; kill = 1'b1; result_ack = 1'b1;
    tick();
    rst = 1'b0; kill = 1'b0; result_ack = 1'b0;
    #1;
    checks++;
    if ({result_valid, result, addr_d_out, wrd_reg_out, stall} !== {1'b0, 32'd0, 5'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_T+6: got v=%b r=%h a=%0d w=%b s=%b expected all zero",
               result_valid, result, addr_d_out, wrd_reg_out, stall);
    end
    for (int c = 0; c < 40; c++) tick();
    checks++;
    if ({result_valid, wrd_reg_out, stall} !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid_no_result: got v=%b w=%b s=%b expected 0 0 0", result_valid, wrd_reg_out, stall);
    end
  endtask

  initial begin
    test_reset();
    test_small();
    test_zero();
    test_worst();
    test_overflow();
    test_delayed_ack();
    test_kill();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
